t_flipflop: RTL and testbench

//   Bank of WIDTH toggle (T) flip-flops on one clock domain. Each bit of Q inverts on a rising clk edge when its T bit is 1.

---
 rtl/t_flipflop.sv | 60 ++++++
 tb/tb_t_flipflop.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t_flipflop.sv
// Bank of WIDTH independent toggle flip-flops with complementary outputs.
// Define TFF_TOGGLE_CNT_EN to add toggle_cnt, a wrapping count of edges with any T bit set.
module t_flipflop #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] T,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar
`ifdef TFF_TOGGLE_CNT_EN
   ,
   output logic [CNT_W-1:0] toggle_cnt
`endif
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q ^ T;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   // Qbar is derived from the same register so the two can never disagree.
   assign Q    = q_q;
   assign Qbar = ~q_q;

`ifdef TFF_TOGGLE_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (|T) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_t_flipflop.sv
// Self-checking bench for t_flipflop: a 1-bit instance (CNT_W=2) and a 4-bit instance
// with RESET_VAL=4'b1010, checked against a reference model through a scoreboard queue.
module tb_t_flipflop;

   typedef struct {
      logic        q1;
      logic [3:0]  q4;
      logic [1:0]  c1;
      logic [15:0] c4;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        T1;
   logic [3:0]  T4;
   logic        Q1, Qbar1;
   logic [3:0]  Q4, Qbar4;
   logic [1:0]  cnt1;
   logic [15:0] cnt4;

   int checks   = 0;
   int failures = 0;

   logic        m1;
   logic [3:0]  m4;
   logic [1:0]  mc1;
   logic [15:0] mc4;
   exp_t        sbq[$];

   t_flipflop #(.WIDTH(1), .RESET_VAL(1'b0), .CNT_W(2)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .T     (T1),
      .Q     (Q1),
      .Qbar  (Qbar1)
`ifdef TFF_TOGGLE_CNT_EN
      ,
      .toggle_cnt (cnt1)
`endif
   );

   t_flipflop #(.WIDTH(4), .RESET_VAL(4'b1010), .CNT_W(16)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .T     (T4),
      .Q     (Q4),
      .Qbar  (Qbar4)
`ifdef TFF_TOGGLE_CNT_EN
      ,
      .toggle_cnt (cnt4)
`endif
   );

`ifndef TFF_TOGGLE_CNT_EN
   assign cnt1 = '0;
   assign cnt4 = '0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model values after a reset.
   task automatic modelReset();
      m1  = 1'b0;
      m4  = 4'b1010;
      mc1 = '0;
      mc4 = '0;
   endtask

   // Drive T at a falling edge, advance the model and push the expected post-edge state.
   task automatic pushStep(input logic t1, input logic [3:0] t4);
      exp_t e;
      @(negedge clk);
      T1 = t1;
      T4 = t4;
      m1 = m1 ^ t1;
      m4 = m4 ^ t4;
      if (t1) mc1 = mc1 + 2'd1;
      if (|t4) mc4 = mc4 + 16'd1;
      e.q1 = m1;
      e.q4 = m4;
      e.c1 = mc1;
      e.c4 = mc4;
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b1;
      T1 = 1'b0;
      T4 = 4'b0000;
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checks++;
      if (Q1 !== 1'b0 || Qbar1 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_async1: Q=%b Qbar=%b expected Q=0 Qbar=1", Q1, Qbar1);
      end
      checks++;
      if (Q4 !== 4'b1010 || Qbar4 !== 4'b0101) begin
         failures++;
         $display("[TB] FAIL reset_async4: Q=%b Qbar=%b expected Q=1010 Qbar=0101", Q4, Qbar4);
      end
      T1 = 1'b1;
      T4 = 4'b1111;
      @(posedge clk);
      #1;
      checks++;
      if (Q1 !== 1'b0 || Q4 !== 4'b1010) begin
         failures++;
         $display("[TB] FAIL reset_edge_ignored: Q1=%b Q4=%b expected Q1=0 Q4=1010", Q1, Q4);
      end
      @(negedge clk);
      T1 = 1'b0;
      T4 = 4'b0000;
      rst_n = 1'b1;
      pushStep(1'b0, 4'b0000);
      e = sbq.pop_front();
      checks++;
      if (Q1 !== e.q1 || Qbar1 !== ~e.q1 || Q4 !== e.q4) begin
         failures++;
         $display("[TB] FAIL reset_release: Q1=%b Qbar1=%b Q4=%b expected Q1=%b Qbar1=%b Q4=%b",
                  Q1, Qbar1, Q4, e.q1, ~e.q1, e.q4);
      end
   endtask

   task automatic test_hold_toggle();
      logic tSeq[5];
      logic qRef[5];
      exp_t e;
      tSeq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      qRef = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         pushStep(tSeq[i], 4'b0000);
         e = sbq.pop_front();
         checks++;
         if (Q1 !== e.q1 || Qbar1 !== ~e.q1 || e.q1 !== qRef[i]) begin
            failures++;
            $display("[TB] FAIL hold_toggle[%0d]: Q=%b Qbar=%b expected Q=%b Qbar=%b",
                     i, Q1, Qbar1, qRef[i], ~qRef[i]);
         end
      end
   endtask

   task automatic test_continuous();
      exp_t e;
      logic prev;
      prev = m1;
      for (int i = 0; i < 8; i++) begin
         pushStep(1'b1, 4'b0000);
         e = sbq.pop_front();
         checks++;
         if (Q1 !== e.q1 || Qbar1 !== ~e.q1 || e.q1 !== ~prev) begin
            failures++;
            $display("[TB] FAIL continuous[%0d]: Q=%b Qbar=%b expected Q=%b Qbar=%b",
                     i, Q1, Qbar1, e.q1, ~e.q1);
         end
         prev = e.q1;
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      if (m1 !== 1'b1) begin
         pushStep(1'b1, 4'b0000);
         e = sbq.pop_front();
         checks++;
         if (Q1 !== e.q1) begin
            failures++;
            $display("[TB] FAIL mid_reset_setup: Q=%b expected %b", Q1, e.q1);
         end
      end
      T1 = 1'b1;
      T4 = 4'b0101;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checks++;
      if (Q1 !== 1'b0 || Qbar1 !== 1'b1 || Q4 !== 4'b1010) begin
         failures++;
         $display("[TB] FAIL mid_reset_async: Q1=%b Qbar1=%b Q4=%b expected Q1=0 Qbar1=1 Q4=1010",
                  Q1, Qbar1, Q4);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Q1 !== 1'b0 || Q4 !== 4'b1010) begin
         failures++;
         $display("[TB] FAIL mid_reset_edge_ignored: Q1=%b Q4=%b expected Q1=0 Q4=1010", Q1, Q4);
      end
      @(negedge clk);
      T1 = 1'b0;
      T4 = 4'b0000;
      rst_n = 1'b1;
   endtask

   task automatic test_wide();
      exp_t e;
      logic [3:0] tSeq[3];
      tSeq = '{4'b0110, 4'b0000, 4'b1111};
      for (int i = 0; i < 3; i++) begin
         pushStep(1'b0, tSeq[i]);
         e = sbq.pop_front();
         checks++;
         if (Q4 !== e.q4 || Qbar4 !== ~e.q4) begin
            failures++;
            $display("[TB] FAIL wide[%0d]: Q=%b Qbar=%b expected Q=%b Qbar=%b",
                     i, Q4, Qbar4, e.q4, ~e.q4);
         end
      end
      checks++;
      if (Q4 !== 4'b0011) begin
         failures++;
         $display("[TB] FAIL wide_final: Q=%b expected 0011", Q4);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [3:0] t4;
      logic t1;
      for (int i = 0; i < 10; i++) begin
         t1 = 1'($urandom_range(0, 1));
         t4 = 4'($urandom_range(0, 15));
         pushStep(t1, t4);
         e = sbq.pop_front();
         checks++;
         if (Q1 !== e.q1 || Qbar1 !== ~e.q1 || Q4 !== e.q4 || Qbar4 !== ~e.q4) begin
            failures++;
            $display("[TB] FAIL back_to_back[%0d]: Q1=%b Q4=%b Qbar4=%b expected Q1=%b Q4=%b Qbar4=%b",
                     i, Q1, Q4, Qbar4, e.q1, e.q4, ~e.q4);
         end
`ifdef TFF_TOGGLE_CNT_EN
         checks++;
         if (cnt1 !== e.c1 || cnt4 !== e.c4) begin
            failures++;
            $display("[TB] FAIL back_to_back_cnt[%0d]: cnt1=%0d cnt4=%0d expected cnt1=%0d cnt4=%0d",
                     i, cnt1, cnt4, e.c1, e.c4);
         end
`endif
      end
   endtask

`ifdef TFF_TOGGLE_CNT_EN
   task automatic test_toggle_count();
      exp_t e;
      logic [1:0] cRef[5];
      cRef = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      @(negedge clk);
      rst_n = 1'b0;
      modelReset();
      #1;
      checks++;
      if (cnt1 !== 2'd0 || cnt4 !== 16'd0) begin
         failures++;
         $display("[TB] FAIL count_reset: cnt1=%0d cnt4=%0d expected 0 0", cnt1, cnt4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pushStep(1'b1, 4'b0000);
         e = sbq.pop_front();
         checks++;
         if (cnt1 !== e.c1 || e.c1 !== cRef[i] || cnt4 !== e.c4) begin
            failures++;
            $display("[TB] FAIL count[%0d]: cnt1=%0d cnt4=%0d expected cnt1=%0d cnt4=%0d",
                     i, cnt1, cnt4, cRef[i], e.c4);
         end
      end
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checks++;
      if (cnt1 !== 2'd0) begin
         failures++;
         $display("[TB] FAIL count_async_clear: cnt1=%0d expected 0", cnt1);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      modelReset();
      test_reset();
      test_hold_toggle();
      test_continuous();
      test_mid_reset();
      test_wide();
      test_back_to_back();
`ifdef TFF_TOGGLE_CNT_EN
      test_toggle_count();
`endif
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
